// File: rtl/mandelbrot_iterator.sv
// Per-pixel Mandelbrot escape-time engine: iterates z <- z^2 + c in signed 4.23,
// one iteration per clock, and reports how many iterations ran before escape.
module mandelbrot_iterator #(
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [26:0]       c_re,
  input  logic [26:0]       c_im,
  input  logic [ITER_W-1:0] max_iter,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] iter_count,
  output logic              escaped,
  output logic [1:0]        dbg_state_o,
  output logic [26:0]       dbg_zr_o,
  output logic [26:0]       dbg_zi_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid is held with stable payload until that edge.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic signed [26:0] TWO      = 27'sh1000000;
  localparam logic signed [26:0] NEG_TWO  = -27'sh1000000;
  localparam logic signed [27:0] FOUR     = 28'sh2000000;
  localparam logic signed [27:0] SAT28_HI = 28'sd67108863;
  localparam logic signed [27:0] SAT28_LO = -28'sd67108864;
  localparam logic signed [28:0] SAT29_HI = 29'sd67108863;
  localparam logic signed [28:0] SAT29_LO = -29'sd67108864;

  logic [1:0]        state_q, state_d;
  logic [26:0]       zr_q, zr_d, zi_q, zi_d;
  logic [26:0]       cre_q, cre_d, cim_q, cim_d;
  logic [ITER_W-1:0] max_q, max_d, n_q, n_d, count_q, count_d;
  logic              esc_q, esc_d;

  logic signed [53:0] p_rr, p_ii, p_ri;
  logic [26:0]        rr, ii, ri;
  logic signed [27:0] mag_sum, zr_sum;
  logic signed [28:0] zi_sum;
  logic               guard, esc;
  logic               unused_bits;

  function automatic logic [26:0] sat28(input logic signed [27:0] v);
    if (v > SAT28_HI)      return 27'h3FFFFFF;
    else if (v < SAT28_LO) return 27'h4000000;
    else                   return v[26:0];
  endfunction

  function automatic logic [26:0] sat29(input logic signed [28:0] v);
    if (v > SAT29_HI)      return 27'h3FFFFFF;
    else if (v < SAT29_LO) return 27'h4000000;
    else                   return v[26:0];
  endfunction

  // Full 8.46 products, truncated back to 4.23; only meaningful while |z| < 2.
  assign p_rr = $signed({{27{zr_q[26]}}, zr_q}) * $signed({{27{zr_q[26]}}, zr_q});
  assign p_ii = $signed({{27{zi_q[26]}}, zi_q}) * $signed({{27{zi_q[26]}}, zi_q});
  assign p_ri = $signed({{27{zr_q[26]}}, zr_q}) * $signed({{27{zi_q[26]}}, zi_q});
  assign rr = p_rr[49:23];
  assign ii = p_ii[49:23];
  assign ri = p_ri[49:23];
  assign unused_bits = ^{p_rr[53:50], p_rr[22:0], p_ii[53:50], p_ii[22:0],
                         p_ri[53:50], p_ri[22:0]};

  assign mag_sum = $signed({rr[26], rr}) + $signed({ii[26], ii});
  assign zr_sum  = $signed({rr[26], rr}) - $signed({ii[26], ii}) + $signed({cre_q[26], cre_q});
  assign zi_sum  = $signed({ri[26], ri, 1'b0}) + $signed({{2{cim_q[26]}}, cim_q});

  // The magnitude guard comes first so a truncated product can never hide an escape.
  assign guard = ($signed(zr_q) >= TWO) || ($signed(zr_q) <= NEG_TWO) ||
                 ($signed(zi_q) >= TWO) || ($signed(zi_q) <= NEG_TWO);
  assign esc   = guard || (mag_sum >= FOUR);

  always_comb begin
    state_d = state_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    cre_d   = cre_q;
    cim_d   = cim_q;
    max_d   = max_q;
    n_d     = n_q;
    count_d = count_q;
    esc_d   = esc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cre_d   = c_re;
          cim_d   = c_im;
          max_d   = max_iter;
          zr_d    = '0;
          zi_d    = '0;
          n_d     = '0;
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        if (esc) begin
          count_d = n_q;
          esc_d   = 1'b1;
          state_d = ST_DONE;
        end else if (n_q == max_q) begin
          count_d = n_q;
          esc_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          n_d  = n_q + ITER_W'(1);
          zr_d = sat28(zr_sum);
          zi_d = sat29(zi_sum);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      zr_q    <= '0;
      zi_q    <= '0;
      cre_q   <= '0;
      cim_q   <= '0;
      max_q   <= '0;
      n_q     <= '0;
      count_q <= '0;
      esc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      cre_q   <= cre_d;
      cim_q   <= cim_d;
      max_q   <= max_d;
      n_q     <= n_d;
      count_q <= count_d;
      esc_q   <= esc_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign iter_count  = count_q;
  assign escaped     = esc_q;
  assign dbg_state_o = state_q;
  assign dbg_zr_o    = zr_q;
  assign dbg_zi_o    = zi_q;

endmodule
